// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
//
// Conditions CHANNELS independent pushbutton inputs. Each channel has:
//   polarity correction -> two-flop synchronizer -> debounce timer -> debounced
//   level with press/release edge pulses -> typematic (auto-repeat) FSM that
//   produces a strobe train and a long-press "held" flag.
//
// Parameters
//   CHANNELS      number of independent channels
//   DEBOUNCE_BITS debounce timer width; input must be stable 2^DEBOUNCE_BITS cycles
//   HOLD          cycles from the press strobe to the first auto-repeat strobe (>= 2)
//   REPEAT        cycles between auto-repeat strobes (>= 1)
//   ACTIVE_LOW    1: a raw input of 0 means "pressed"
//
// Ports
//   clk        single clock, all state on rising edge
//   reset_n    synchronous active-low reset
//   raw        asynchronous button inputs
//   repeat_en  per-channel auto-repeat enable, sampled every cycle
//   level      debounced level, 1 = pressed
//   press      one-cycle pulse, cycle after level rises
//   release_o  one-cycle pulse, cycle after level falls
//              ('release' is a reserved word in SystemVerilog)
//   strobe     typematic pulse train (press, then HOLD, then every REPEAT)
//   held       long-press flag, set HOLD cycles after press until release
// -----------------------------------------------------------------------------
module key_conditioner #(
    parameter int CHANNELS      = 4,
    parameter int DEBOUNCE_BITS = 14,
    parameter int HOLD          = 25_000_000,
    parameter int REPEAT        = 5_000_000,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] raw,
    input  logic [CHANNELS-1:0] repeat_en,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_o,
    output logic [CHANNELS-1:0] strobe,
    output logic [CHANNELS-1:0] held
);

    localparam int CNT_MAX = (HOLD > REPEAT) ? HOLD : REPEAT;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0]         HOLD_LAST   = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0]         REPEAT_LAST = CNT_W'(REPEAT - 1);
    localparam logic [DEBOUNCE_BITS-1:0] TIMER_MAX   = {DEBOUNCE_BITS{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_HOLD = 2'd1,
        ST_REPEATING = 2'd2
    } state_t;

    // Polarity is applied before synchronization so every later stage sees
    // 1 = pressed regardless of board wiring.
    logic [CHANNELS-1:0] raw_pol;
    assign raw_pol = (ACTIVE_LOW != 0) ? ~raw : raw;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic                     sync0_q, sync0_d;
        logic                     sync1_q, sync1_d;
        logic                     level_q, level_d;
        logic                     level_prev_q, level_prev_d;
        logic [DEBOUNCE_BITS-1:0] timer_q, timer_d;
        logic                     press_q, press_d;
        logic                     release_q, release_d;
        logic                     strobe_q, strobe_d;
        logic                     held_q, held_d;
        logic [CNT_W-1:0]         cnt_q, cnt_d;
        state_t                   state_q, state_d;
        logic                     rise;
        logic                     fall;

        // Debounced edges are detected one cycle after level changes, which is
        // what places press/release (and the FSM reaction) in the following cycle.
        assign rise = level_q & ~level_prev_q;
        assign fall = ~level_q & level_prev_q;

        // Synchronizer, debounce timer and edge pulses.
        always_comb begin
            sync0_d      = raw_pol[i];
            sync1_d      = sync0_q;
            level_d      = level_q;
            timer_d      = timer_q;
            level_prev_d = level_q;
            press_d      = rise;
            release_d    = fall;
            if (sync1_q == level_q) begin
                // Any agreement (including a bounce back) restarts the count.
                timer_d = '0;
            end else if (timer_q == TIMER_MAX) begin
                level_d = ~level_q;
                timer_d = '0;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end

        // Typematic FSM: next state, repeat counter, strobe and held.
        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            strobe_d = 1'b0;
            held_d   = held_q;
            if (fall) begin
                // A release aborts from any state, same cycle as release_o.
                state_d = ST_IDLE;
                cnt_d   = '0;
                held_d  = 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rise) begin
                            state_d  = ST_WAIT_HOLD;
                            cnt_d    = '0;
                            strobe_d = 1'b1;
                        end else begin
                            cnt_d = '0;
                        end
                    end
                    ST_WAIT_HOLD: begin
                        if (cnt_q == HOLD_LAST) begin
                            state_d  = ST_REPEATING;
                            cnt_d    = '0;
                            held_d   = 1'b1;
                            strobe_d = repeat_en[i];
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    ST_REPEATING: begin
                        if (cnt_q == REPEAT_LAST) begin
                            cnt_d    = '0;
                            strobe_d = repeat_en[i];
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        held_d  = 1'b0;
                    end
                endcase
            end
        end

        // Channel state register with synchronous active-low reset.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                sync0_q      <= 1'b0;
                sync1_q      <= 1'b0;
                level_q      <= 1'b0;
                level_prev_q <= 1'b0;
                timer_q      <= '0;
                press_q      <= 1'b0;
                release_q    <= 1'b0;
                strobe_q     <= 1'b0;
                held_q       <= 1'b0;
                cnt_q        <= '0;
                state_q      <= ST_IDLE;
            end else begin
                sync0_q      <= sync0_d;
                sync1_q      <= sync1_d;
                level_q      <= level_d;
                level_prev_q <= level_prev_d;
                timer_q      <= timer_d;
                press_q      <= press_d;
                release_q    <= release_d;
                strobe_q     <= strobe_d;
                held_q       <= held_d;
                cnt_q        <= cnt_d;
                state_q      <= state_d;
            end
        end

        assign level[i]     = level_q;
        assign press[i]     = press_q;
        assign release_o[i] = release_q;
        assign strobe[i]    = strobe_q;
        assign held[i]      = held_q;
    end

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

    localparam int CH   = 2;
    localparam int DB   = 2;
    localparam int HOLD = 8;
    localparam int REP  = 3;
    localparam int AL   = 1;
    localparam int WIN  = 1 << DB;
    localparam int MAXC = 8192;

    localparam int EV_LVL_UP  = 0;
    localparam int EV_LVL_DN  = 1;
    localparam int EV_PRESS   = 2;
    localparam int EV_RELEASE = 3;
    localparam int EV_STROBE  = 4;
    localparam int EV_HELD_UP = 5;
    localparam int EV_HELD_DN = 6;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [CH-1:0] raw = 2'b11;
    logic [CH-1:0] repeat_en = 2'b00;
    logic [CH-1:0] level, press, release_o, strobe, held;

    always #5 clk = ~clk;

    key_conditioner #(
        .CHANNELS(CH), .DEBOUNCE_BITS(DB), .HOLD(HOLD), .REPEAT(REP), .ACTIVE_LOW(AL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .raw(raw), .repeat_en(repeat_en),
        .level(level), .press(press), .release_o(release_o),
        .strobe(strobe), .held(held)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int ch;
        int kind;
    } ev_t;
    ev_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_on  = 1'b0;

    // ---------------- reference model (rule level) ----------------
    bit h0 [CH][MAXC];   // pressed value loaded into the first sync stage at each edge
    bit rs [MAXC];       // reset asserted at edge
    bit m_lvl [CH];
    bit m_rose [CH];
    bit m_fell [CH];
    bit m_act [CH];
    bit m_held [CH];
    int m_p [CH];
    int last_edge = 0;

    function automatic bit seen(int c, int m);
        if (m < 2) return 1'b0;
        if (rs[m-1]) return 1'b0;
        return h0[c][m-2];
    endfunction

    // level flips at edge n when the synchronized value has disagreed with the
    // level on every one of the last WIN reset-free edges
    function automatic bit flips(int c, int n, bit lvl);
        if (n - WIN + 1 < 1) return 1'b0;
        for (int j = 0; j < WIN; j++) begin
            if (rs[n-j]) return 1'b0;
            if (seen(c, n-j) == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void push(int n, int c, int k);
        ev_t e;
        e.cyc = n; e.ch = c; e.kind = k;
        exp_q.push_back(e);
    endfunction

    function automatic void model_edge(int n, logic [CH-1:0] r, logic [CH-1:0] en, logic rn);
        bit tog;
        int d;
        rs[n] = !rn;
        for (int c = 0; c < CH; c++) begin
            h0[c][n] = rn ? ((AL != 0) ? ~r[c] : r[c]) : 1'b0;
            if (!rn) begin
                if (m_lvl[c])  push(n, c, EV_LVL_DN);
                if (m_held[c]) push(n, c, EV_HELD_DN);
                m_lvl[c] = 0; m_rose[c] = 0; m_fell[c] = 0; m_act[c] = 0; m_held[c] = 0;
            end else begin
                tog = flips(c, n, m_lvl[c]);
                if (tog) push(n, c, m_lvl[c] ? EV_LVL_DN : EV_LVL_UP);
                if (m_rose[c]) push(n, c, EV_PRESS);
                if (m_fell[c]) push(n, c, EV_RELEASE);
                if (m_fell[c]) begin
                    if (m_held[c]) push(n, c, EV_HELD_DN);
                    m_act[c] = 0; m_held[c] = 0;
                end else if (m_rose[c]) begin
                    push(n, c, EV_STROBE);
                    m_act[c] = 1; m_p[c] = n;
                end else if (m_act[c]) begin
                    d = n - m_p[c];
                    if (d >= HOLD && ((d - HOLD) % REP) == 0 && en[c]) push(n, c, EV_STROBE);
                    if (d == HOLD) begin
                        m_held[c] = 1;
                        push(n, c, EV_HELD_UP);
                    end
                end
                m_rose[c] = tog && !m_lvl[c];
                m_fell[c] = tog && m_lvl[c];
                if (tog) m_lvl[c] = !m_lvl[c];
            end
        end
    endfunction

    // ---------------- monitor ----------------
    logic [CH-1:0] plv = '0, phd = '0;
    int last_press_cyc [CH];
    int press_cnt [CH];
    int held_up_cnt [CH];
    int last_held_up_cyc [CH];

    function automatic bit dut_ev(int c, int k);
        case (k)
            EV_LVL_UP:  return level[c] & ~plv[c];
            EV_LVL_DN:  return ~level[c] & plv[c];
            EV_PRESS:   return press[c];
            EV_RELEASE: return release_o[c];
            EV_STROBE:  return strobe[c];
            EV_HELD_UP: return held[c] & ~phd[c];
            EV_HELD_DN: return ~held[c] & phd[c];
            default:    return 1'b0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (mon_on) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_tests++; n_fail++;
                $display("FAIL missing_event: DUT showed nothing, expected ch%0d kind%0d at cycle %0d",
                         exp_q[0].ch, exp_q[0].kind, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            for (int c = 0; c < CH; c++) begin
                for (int k = 0; k < 7; k++) begin
                    if (dut_ev(c, k)) begin
                        if (k == EV_PRESS) begin
                            last_press_cyc[c] = cyc; press_cnt[c]++;
                        end
                        if (k == EV_HELD_UP) begin
                            last_held_up_cyc[c] = cyc; held_up_cnt[c]++;
                        end
                        n_tests++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_event: got ch%0d kind%0d at cycle %0d, expected none",
                                     c, k, cyc);
                        end else begin
                            ev_t e;
                            e = exp_q.pop_front();
                            if (e.cyc != cyc || e.ch != c || e.kind != k) begin
                                n_fail++;
                                $display("FAIL event: got ch%0d kind%0d cycle %0d, expected ch%0d kind%0d cycle %0d",
                                         c, k, cyc, e.ch, e.kind, e.cyc);
                            end
                        end
                    end
                end
            end
            plv = level;
            phd = held;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [CH-1:0] r, input logic [CH-1:0] en, input logic rn);
        @(negedge clk);
        raw = r; repeat_en = en; reset_n = rn;
        last_edge = cyc + 1;
        model_edge(cyc + 1, r, en, rn);
    endtask

    task automatic hold(input logic [CH-1:0] r, input logic [CH-1:0] en, input int n);
        for (int i = 0; i < n; i++) step(r, en, 1'b1);
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    initial begin
        int e0, er, pc, hc;
        logic [CH-1:0] rr, ee;
        logic rn;
        for (int c = 0; c < CH; c++) begin
            last_press_cyc[c] = -1; press_cnt[c] = 0; held_up_cnt[c] = 0; last_held_up_cyc[c] = -1;
        end
        for (int i = 0; i < 3; i++) step(2'b11, 2'b00, 1'b0);
        @(negedge clk);
        check_int("reset_outputs", int'({level, press, release_o, strobe, held}), 0);
        mon_on = 1'b1;
        hold(2'b11, 2'b11, 5);

        // clean press with typematic on channel 0
        step(2'b10, 2'b11, 1'b1);
        e0 = last_edge;
        hold(2'b10, 2'b11, 30);
        check_int("clean_press_cycle", last_press_cyc[0], e0 + 6);
        check_int("held_rise_cycle", last_held_up_cyc[0], e0 + 6 + HOLD);
        check_int("ch1_untouched", press_cnt[1], 0);
        hold(2'b11, 2'b11, 15);

        // typematic disabled
        hold(2'b10, 2'b00, 25);
        hold(2'b11, 2'b00, 15);

        // bounce then stable low
        pc = press_cnt[0];
        for (int i = 0; i < 10; i++) hold((i % 2) ? 2'b11 : 2'b10, 2'b01, 2);
        step(2'b10, 2'b01, 1'b1);
        e0 = last_edge;
        hold(2'b10, 2'b01, 15);
        hold(2'b11, 2'b01, 15);
        check_int("bounce_press_count", press_cnt[0] - pc, 1);
        check_int("bounce_press_cycle", last_press_cyc[0], e0 + 6);

        // early release: release pulse lands at P+5
        hc = held_up_cnt[0];
        hold(2'b10, 2'b01, 5);
        hold(2'b11, 2'b01, 20);
        check_int("early_release_no_held", held_up_cnt[0] - hc, 0);

        // reset in the middle of auto-repeat with the button held
        hold(2'b10, 2'b01, 18);
        step(2'b10, 2'b01, 1'b0);
        step(2'b10, 2'b01, 1'b0);
        step(2'b10, 2'b01, 1'b1);
        er = last_edge;
        hold(2'b10, 2'b01, 20);
        check_int("repress_after_reset", last_press_cyc[0], er + 6);
        hold(2'b11, 2'b01, 15);

        // simultaneous press, repeat on channel 0 only
        hold(2'b00, 2'b01, 25);
        check_int("simul_press", last_press_cyc[1], last_press_cyc[0]);
        check_int("simul_held", last_held_up_cyc[1], last_held_up_cyc[0]);
        hold(2'b11, 2'b01, 15);

        // randomized phase
        rr = 2'b11; ee = 2'b00;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 11) == 0) rr[c] = ~rr[c];
                if ($urandom_range(0, 19) == 0) ee[c] = ~ee[c];
            end
            rn = ($urandom_range(0, 299) != 0);
            step(rr, ee, rn);
        end
        hold(2'b11, 2'b00, 30);
        @(negedge clk);
        @(negedge clk);
        check_int("leftover_expected", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
